// File: rtl/gmux_switch_ctrl.sv
// Select controller for a bank of GMUX clock muxes: one-hot enables with an
// all-off dead gap on every handover. Optional macro GMUX_SW_FORCE_OFF_EN.
module gmux_switch_ctrl #(
    parameter int N_CH       = 5,
    parameter int SEL_W      = $clog2(N_CH),
    parameter int DEAD_CYC   = 2,
    parameter int DEFAULT_CH = 0
) (
    input  logic             QCK,
    input  logic             QRT,
    input  logic             req_valid,
    input  logic [SEL_W-1:0] req_sel,
    output logic             req_ready,
    output logic [N_CH-1:0]  IS,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
`ifdef GMUX_SW_FORCE_OFF_EN
    input  logic             force_off,
`endif
    output logic             err
);

    localparam int CNT_W = $clog2(DEAD_CYC + 1);
    localparam logic [N_CH-1:0] L_ONE = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [N_CH-1:0] L_DEF_OH = L_ONE << DEFAULT_CH;
    localparam logic [SEL_W:0] L_NCH = (SEL_W+1)'(N_CH);
    localparam logic [CNT_W-1:0] L_DEAD = CNT_W'(DEAD_CYC);

    if (N_CH < 2) begin : g_bad_nch
        $error("gmux_switch_ctrl: N_CH must be >= 2");
    end
    if (DEAD_CYC < 1) begin : g_bad_dead
        $error("gmux_switch_ctrl: DEAD_CYC must be >= 1");
    end
    if (DEFAULT_CH >= N_CH) begin : g_bad_def
        $error("gmux_switch_ctrl: DEFAULT_CH out of range");
    end

`ifdef GMUX_SW_FORCE_OFF_EN
    typedef enum logic [1:0] {ST_ON, ST_GAP, ST_FORCED} state_t;
`else
    typedef enum logic {ST_ON, ST_GAP} state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_target;

    logic             w_oob;
    logic             w_accept;
    logic [N_CH-1:0]  w_tgt_oh;

    assign w_oob    = {1'b0, req_sel} >= L_NCH;
    assign w_accept = req_valid & req_ready;
    assign w_tgt_oh = L_ONE << r_target;

    // Handover FSM: enables drop, counter runs out the gap, new enable rises.
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            r_state   <= ST_ON;
            r_cnt     <= '0;
            r_target  <= SEL_W'(DEFAULT_CH);
            IS        <= L_DEF_OH;
            cur_sel   <= SEL_W'(DEFAULT_CH);
            req_ready <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
`ifdef GMUX_SW_FORCE_OFF_EN
            if (force_off) begin
                r_state   <= ST_FORCED;
                IS        <= '0;
                busy      <= 1'b1;
                req_ready <= 1'b0;
            end else begin
`else
            begin
`endif
                case (r_state)
                    ST_ON: begin
                        if (w_accept) begin
                            if (w_oob) begin
                                err <= 1'b1;
                            end else if (req_sel != cur_sel) begin
                                r_target  <= req_sel;
                                r_cnt     <= L_DEAD;
                                r_state   <= ST_GAP;
                                IS        <= '0;
                                busy      <= 1'b1;
                                req_ready <= 1'b0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (r_cnt == '0) begin
                            IS        <= w_tgt_oh;
                            cur_sel   <= r_target;
                            r_state   <= ST_ON;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
`ifdef GMUX_SW_FORCE_OFF_EN
                    ST_FORCED: begin
                        // Target still holds a pending switch, or cur_sel.
                        r_cnt   <= L_DEAD;
                        r_state <= ST_GAP;
                    end
`endif
                    default: begin
                        r_state <= ST_ON;
                    end
                endcase
            end
        end
    end

endmodule
